// File: rtl/video_scan_doubler.sv
// video_scan_doubler
//   Splits a composite-style sync/pixel pair into separate active-low hsync and
//   vsync, buffers each input line in a ping-pong 1-bit line store and replays
//   it twice per input line on a free-standing output horizontal timebase.
//   Optional feature macro: SCANDOUBLER_SCANLINES_EN -- when defined the second
//   repetition of every line is blanked (scanline look); sync timing unchanged.
module video_scan_doubler #(
  parameter int LINE_PIXELS   = 256,
  parameter int SAMPLE_DIV    = 2,
  parameter int H_SKIP        = 32,
  parameter int SYNC_MIN      = 8,
  parameter int VSYNC_MIN     = 200,
  parameter int OUT_H_TOTAL   = 400,
  parameter int OUT_HSYNC_LEN = 48,
  parameter int OUT_H_START   = 96
) (
  input  logic clk,
  input  logic reset,
  input  logic videoSync,
  input  logic videoPixel,
  output logic hsyncN,
  output logic vsyncN,
  output logic pixelOut,
  output logic lineStart
);

  localparam int LW = $clog2(VSYNC_MIN + 1);
  localparam int AW = $clog2(LINE_PIXELS);
  localparam int CW = $clog2(LINE_PIXELS + 1);
  localparam int WW = $clog2(H_SKIP + SAMPLE_DIV);
  localparam int HW = $clog2(OUT_H_TOTAL + 2);
  localparam int VW = $clog2(2 * OUT_H_TOTAL + 2);

  localparam logic [LW-1:0] LOW_SAT   = LW'(VSYNC_MIN);
  localparam logic [HW-1:0] H_LAST    = HW'(OUT_H_TOTAL - 1);
  localparam logic [HW-1:0] HS_LAST   = HW'(OUT_HSYNC_LEN);
  localparam logic [HW-1:0] PIX_FIRST = HW'(OUT_H_START + 1);
  localparam logic [HW-1:0] PIX_END   = HW'(OUT_H_START + 1 + LINE_PIXELS);
  // One clock of headroom so vsync goes low on the cycle after the edge.
  localparam logic [VW-1:0] VS_LOAD   = VW'(2 * OUT_H_TOTAL + 1);
  localparam logic [VW-1:0] VS_LOW    = VW'(2 * OUT_H_TOTAL);

  // ---------------------------------------------------------------- classifier
  logic [LW-1:0] low_cnt_q;
  logic          hline;
  logic          vline;

  assign hline = videoSync && (low_cnt_q >= LW'(SYNC_MIN)) && (low_cnt_q < LOW_SAT);
  assign vline = videoSync && (low_cnt_q == LOW_SAT);

  // Count consecutive low clocks of videoSync, saturating at the vertical threshold.
  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset)                    low_cnt_q <= '0;
    else if (videoSync)           low_cnt_q <= '0;
    else if (low_cnt_q != LOW_SAT) low_cnt_q <= low_cnt_q + 1'b1;
  end

  // ------------------------------------------------------ sampler / line banks
  logic          wr_bank_q;
  logic [CW-1:0] wr_cnt_q;
  logic [CW-1:0] rd_cnt_q [2];
  logic          samp_run_q;
  logic [WW-1:0] wait_q;
  logic [AW-1:0] k_q;
  logic          samp_slot;
  logic          rd_bank;

  assign samp_slot = samp_run_q && (wait_q == '0) && !hline && !vline;
  assign rd_bank   = ~wr_bank_q;

  // Bank swap on line start, sample scheduling and write-count tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_bank_q   <= 1'b0;
      wr_cnt_q    <= '0;
      rd_cnt_q[0] <= '0;
      rd_cnt_q[1] <= '0;
      samp_run_q  <= 1'b0;
      wait_q      <= '0;
      k_q         <= '0;
    end else if (hline) begin
      wr_bank_q           <= ~wr_bank_q;
      rd_cnt_q[wr_bank_q] <= wr_cnt_q;
      wr_cnt_q            <= '0;
      samp_run_q          <= 1'b1;
      wait_q              <= WW'(H_SKIP - 1);
      k_q                 <= '0;
    end else if (vline) begin
      wr_cnt_q   <= '0;
      samp_run_q <= 1'b0;
    end else if (samp_run_q) begin
      if (wait_q == '0) begin
        // A slot that lands while sync is low is skipped but the schedule runs on.
        if (videoSync) wr_cnt_q <= wr_cnt_q + 1'b1;
        k_q    <= k_q + 1'b1;
        wait_q <= WW'(SAMPLE_DIV - 1);
        if (k_q == AW'(LINE_PIXELS - 1)) samp_run_q <= 1'b0;
      end else begin
        wait_q <= wait_q - 1'b1;
      end
    end
  end

  logic [LINE_PIXELS-1:0] mem_q [2];

  // Line store write port; read and write banks are always different.
  // NOTE: the line store has no reset; per-bank read counts keep stale bits off screen.
  always_ff @(posedge clk) begin
    if (!reset && samp_slot && videoSync) mem_q[wr_bank_q][k_q] <= videoPixel;
  end

  // ------------------------------------------------------- output generator
  logic          gen_act_q, gen_act_d;
  logic          gen_rep_q, gen_rep_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vs_cnt_q, vs_cnt_d;

  // Next horizontal position: restart on line start, idle after the second repetition.
  // NOTE: every always_comb output gets a default first, so no latch can be inferred.
  always_comb begin
    gen_act_d = gen_act_q;
    gen_rep_d = gen_rep_q;
    hcnt_d    = hcnt_q;
    vs_cnt_d  = vs_cnt_q;
    if (hline) begin
      gen_act_d = 1'b1;
      gen_rep_d = 1'b0;
      hcnt_d    = '0;
    end else if (gen_act_q) begin
      if (hcnt_q == H_LAST) begin
        hcnt_d = '0;
        if (gen_rep_q) gen_act_d = 1'b0;
        else           gen_rep_d = 1'b1;
      end else begin
        hcnt_d = hcnt_q + 1'b1;
      end
    end
    if (vline)                vs_cnt_d = VS_LOAD;
    else if (vs_cnt_q != '0)  vs_cnt_d = vs_cnt_q - 1'b1;
  end

  logic          pix_win;
  logic          pix_show;
  logic [AW-1:0] pix_idx;
  logic          pix_lit;

  assign pix_win = gen_act_d && (hcnt_d >= PIX_FIRST) && (hcnt_d < PIX_END);
  assign pix_idx = AW'(hcnt_d - PIX_FIRST);
  // Indices at or past the captured count read as black.
  assign pix_lit = mem_q[rd_bank][pix_idx] && (CW'(pix_idx) < rd_cnt_q[rd_bank]);

`ifdef SCANDOUBLER_SCANLINES_EN
  assign pix_show = pix_win && !gen_rep_d;
`else
  assign pix_show = pix_win;
`endif

  logic hsync_n_q, vsync_n_q, pixel_q, line_start_q;

  // Register timebase state and all outputs from the next-state values.
  always_ff @(posedge clk) begin
    if (reset) begin
      gen_act_q    <= 1'b0;
      gen_rep_q    <= 1'b0;
      hcnt_q       <= '0;
      vs_cnt_q     <= '0;
      hsync_n_q    <= 1'b1;
      vsync_n_q    <= 1'b1;
      pixel_q      <= 1'b0;
      line_start_q <= 1'b0;
    end else begin
      gen_act_q    <= gen_act_d;
      gen_rep_q    <= gen_rep_d;
      hcnt_q       <= hcnt_d;
      vs_cnt_q     <= vs_cnt_d;
      hsync_n_q    <= !(gen_act_d && (hcnt_d != '0) && (hcnt_d <= HS_LAST));
      vsync_n_q    <= !((vs_cnt_d != '0) && (vs_cnt_d <= VS_LOW));
      pixel_q      <= pix_show && pix_lit;
      line_start_q <= hline;
    end
  end

  assign hsyncN    = hsync_n_q;
  assign vsyncN    = vsync_n_q;
  assign pixelOut  = pixel_q;
  assign lineStart = line_start_q;

endmodule
